// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// small address helpers used by the top and the byte-lane sub-module.
// Purely declarative; no logic of its own.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        DONE   = 2'b11
    } lsu_state_t;

    // Byte offset of the addressed lane after aligning down to the access size.
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] adr_lo);
        case (size)
            SIZE_B:  return adr_lo;
            SIZE_H:  return {adr_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // Accesses that cannot be served without alignment fix-up (reserved size included).
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] adr_lo);
        return ((size == SIZE_H) && adr_lo[0]) ||
               ((size == SIZE_W) && (adr_lo != 2'b00)) ||
               (size == SIZE_R);
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian lane helper: extracts and sign/zero-extends a byte or halfword,
// and merges store data into a word. Combinational, zero latency, no handshake.
// Ports: word (memory word), offset (lane), size, is_unsigned, wdata (right-justified)
//        -> load_data (extended result), store_data (merged word; wdata for word size).
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        // Offset 0 is the most significant byte, so the bit position is 8*(3-offset).
        byte_sh    = {~offset, 3'b000};
        half_sh    = {~offset[1], 4'b0000};
        byte_val   = word[byte_sh +: 8];
        half_val   = word[half_sh +: 16];
        load_data  = word;
        store_data = wdata;
        case (size)
            SIZE_B: begin
                load_data  = is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
                store_data = word;
                store_data[byte_sh +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                load_data  = is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
                store_data = word;
                store_data[half_sh +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between core and a word-wide big-endian memory (sub-word
// stores are read-modify-write). Latency: load/word store 2, sub-word store 3,
// trapped access 1. Backpressure: req_ready only in IDLE; responses cannot stall.
// Ports: req_* (core request), resp_* (one-cycle completion), mem_adr /
// to_be_written_data / MemWrite / read_data (memory, combinational read).
// Option: LSU_MISALIGN_TRAP_EN turns misaligned/reserved-size accesses into
// 1-cycle error responses; otherwise addresses are aligned down and size 11 is a word.
module load_store_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N-1:0] req_adr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic [N-1:0] mem_adr,
    output logic [N-1:0] to_be_written_data,
    output logic         MemWrite,
    input  logic [N-1:0] read_data
);
    import lsu_pkg::*;

    lsu_state_t   state, state_n;
    logic         accept;
    logic         wr_q, uns_q;
    logic [1:0]   size_q;
    logic [N-1:0] adr_q, wdata_q, data_q;
    logic         sub_store;
    logic         rdata_en;
    logic [1:0]   offset;
    logic [N-1:0] lane_word, load_ext, merged;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    logic trap;
    assign trap = is_misaligned(req_size, req_adr[1:0]);
`endif

    // rst_n gating keeps req_ready low for the whole reset window.
    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign sub_store = (size_q != SIZE_W);
    assign offset    = lane_offset(size_q, adr_q[1:0]);
    // In WRITE the lane merges into the word captured during ACCESS.
    assign lane_word = (state == WRITE) ? data_q : read_data;

    lsu_byte_lane u_lane (
        .word        (lane_word),
        .offset      (offset),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_ext),
        .store_data  (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n            = state;
        mem_adr            = '0;
        MemWrite           = 1'b0;
        to_be_written_data = '0;
        resp_valid         = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_n = trap ? DONE : ACCESS;
`else
                    state_n = ACCESS;
`endif
                end
            end
            ACCESS: begin
                mem_adr = {adr_q[N-1:2], 2'b00};
                if (wr_q && !sub_store) begin
                    MemWrite           = 1'b1;
                    to_be_written_data = wdata_q;
                    state_n            = DONE;
                end else if (wr_q) begin
                    state_n = WRITE;
                end else begin
                    state_n = DONE;
                end
            end
            WRITE: begin
                mem_adr            = {adr_q[N-1:2], 2'b00};
                MemWrite           = 1'b1;
                to_be_written_data = merged;
                state_n            = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Load data is only returned for real loads; stores and traps read as zero.
`ifdef LSU_MISALIGN_TRAP_EN
    assign rdata_en   = (state == DONE) && !wr_q && !err_q;
    assign resp_err   = (state == DONE) && err_q;
`else
    assign rdata_en   = (state == DONE) && !wr_q;
    assign resp_err   = 1'b0;
`endif
    assign resp_rdata = rdata_en ? data_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SIZE_W;
            adr_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                uns_q   <= req_unsigned;
                size_q  <= (req_size == SIZE_R) ? SIZE_W : req_size;
                adr_q   <= req_adr;
                wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                err_q   <= trap;
`endif
            end
            // Loads keep the extended result; sub-word stores keep the raw word for merging.
            if (state == ACCESS) data_q <= wr_q ? read_data : load_ext;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_adr, req_wdata, resp_rdata, mem_adr, to_be_written_data, read_data;
    logic        resp_valid, resp_err, MemWrite;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_dat = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_adr(req_adr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_adr(mem_adr),
        .to_be_written_data(to_be_written_data), .MemWrite(MemWrite), .read_data(read_data)
    );

    // Memory environment: combinational read, write on clock edge, preload port.
    assign read_data = mem[mem_adr[9:2]];
    always @(posedge clk) begin
        if (MemWrite)    mem[mem_adr[9:2]] <= to_be_written_data;
        else if (pre_we) mem[pre_idx]      <= pre_dat;
    end

    // ---------------- reference model (big-endian byte arithmetic) ----------------
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [1:0] sz, input logic uns);
        int off;
        logic [31:0] v;
        off = int'(a[1:0]);
        if (sz == 2'd0) begin
            v = (word >> (24 - 8*off)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            off = (off / 2) * 2;
            v = (word >> (16 - 8*off)) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] wd);
        int off;
        logic [31:0] mask;
        off = int'(a[1:0]);
        if (sz == 2'd0) begin
            mask = 32'hFF << (24 - 8*off);
            return (word & ~mask) | ((wd & 32'hFF) << (24 - 8*off));
        end else if (sz == 2'd1) begin
            off = (off / 2) * 2;
            mask = 32'hFFFF << (16 - 8*off);
            return (word & ~mask) | ((wd & 32'hFFFF) << (16 - 8*off));
        end
        return wd;
    endfunction

    function automatic logic model_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = a[9:2]; pre_dat = v;
        ref_mem[a[9:2]] = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue one request and observe until its response (bounded).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nwr, output logic [31:0] wr_adr, output logic [31:0] wr_dat,
                          output logic touched, output logic ok);
        int waited;
        rd = '0; er = 1'b0; lat = 0; nwr = 0; wr_adr = '0; wr_dat = '0; touched = 1'b0; ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_adr = a; req_wdata = wd;
        waited = 0;
        while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
        if (!req_ready) begin ok = 1'b0; req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        // Scramble request fields: the unit must have latched them.
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_adr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (lat <= 10) begin
            if (MemWrite) begin nwr++; wr_adr = mem_adr; wr_dat = to_be_written_data; end
            if (MemWrite || mem_adr != 0) touched = 1'b1;
            if (resp_valid) begin rd = resp_rdata; er = resp_err; break; end
            @(negedge clk);
            lat++;
        end
        if (lat > 10) ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_adr = 32'h3E8; req_wdata = 32'h0;
        #2;
        checks++;
        if ({req_ready, resp_valid, resp_err, MemWrite} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {req_ready, resp_valid, resp_err, MemWrite});
        end
        checks++;
        if ({resp_rdata, mem_adr, to_be_written_data} !== 96'h0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h exp 0", resp_rdata, mem_adr, to_be_written_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_held got %b exp 0", req_ready); end
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_load_word();
        logic [31:0] rd, wa, wdt; logic er, t, ok; int lat, nwr;
        poke(32'h3E8, 32'h1122_3344);
        do_req(1'b0, 2'd2, 1'b0, 32'h3E8, 32'h0, rd, er, lat, nwr, wa, wdt, t, ok);
        checks++;
        if (!ok || lat != 2) begin errors++; $display("FAIL lw_latency got %0d ok %0b exp 2", lat, ok); end
        checks++;
        if (rd !== 32'h1122_3344) begin errors++; $display("FAIL lw_data got %h exp 11223344", rd); end
        checks++;
        if (nwr != 0 || er !== 1'b0) begin errors++; $display("FAIL lw_nowrite got wr %0d err %b exp 0/0", nwr, er); end
    endtask

    task automatic test_byte_loads();
        logic [31:0] rd, wa, wdt; logic er, t, ok; int lat, nwr;
        poke(32'h3E8, 32'h80FF_7F01);
        do_req(1'b0, 2'd0, 1'b0, 32'h3E9, 32'h0, rd, er, lat, nwr, wa, wdt, t, ok);
        checks++;
        if (!ok || rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_signed got %h exp ffffffff", rd); end
        do_req(1'b0, 2'd0, 1'b1, 32'h3E8, 32'h0, rd, er, lat, nwr, wa, wdt, t, ok);
        checks++;
        if (!ok || rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h exp 00000080", rd); end
        do_req(1'b0, 2'd1, 1'b0, 32'h3EA, 32'h0, rd, er, lat, nwr, wa, wdt, t, ok);
        checks++;
        if (!ok || rd !== 32'h0000_7F01) begin errors++; $display("FAIL lh_low got %h exp 00007f01", rd); end
    endtask

    task automatic test_half_store();
        logic [31:0] rd, wa, wdt; logic er, t, ok; int lat, nwr;
        poke(32'h3EC, 32'hAABB_CCDD);
        do_req(1'b1, 2'd1, 1'b0, 32'h3EE, 32'hFFFF_1234, rd, er, lat, nwr, wa, wdt, t, ok);
        ref_mem[32'h3EC >> 2] = 32'hAABB_1234;
        checks++;
        if (!ok || lat != 3 || nwr != 1) begin errors++; $display("FAIL sh_timing got lat %0d wr %0d exp 3/1", lat, nwr); end
        checks++;
        if (wdt !== 32'hAABB_1234 || wa !== 32'h3EC) begin errors++; $display("FAIL sh_data got %h@%h exp aabb1234@3ec", wdt, wa); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL sh_rdata got %h exp 0", rd); end
        do_req(1'b0, 2'd2, 1'b0, 32'h3EC, 32'h0, rd, er, lat, nwr, wa, wdt, t, ok);
        checks++;
        if (!ok || rd !== 32'hAABB_1234) begin errors++; $display("FAIL sh_readback got %h exp aabb1234", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, wa, wdt; logic er, t, ok; int lat, nwr;
        poke(32'h3E8, 32'h80FF_7F01);
        do_req(1'b0, 2'd1, 1'b0, 32'h3E9, 32'h0, rd, er, lat, nwr, wa, wdt, t, ok);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (!ok || lat != 1 || er !== 1'b1) begin errors++; $display("FAIL mis_trap got lat %0d err %b exp 1/1", lat, er); end
        checks++;
        if (rd !== 32'h0 || t) begin errors++; $display("FAIL mis_noaccess got rd %h touched %b exp 0/0", rd, t); end
`else
        checks++;
        if (!ok || lat != 2 || er !== 1'b0) begin errors++; $display("FAIL mis_align got lat %0d err %b exp 2/0", lat, er); end
        checks++;
        if (rd !== 32'hFFFF_80FF) begin errors++; $display("FAIL mis_data got %h exp ffff80ff", rd); end
`endif
    endtask

    task automatic test_reset_mid_write();
        int waited, seen;
        poke(32'h3F0, 32'h0102_0304);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_adr = 32'h3F1; req_wdata = 32'h0000_00AA;
        waited = 0;
        while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (MemWrite !== 1'b1) begin errors++; $display("FAIL rmw_write_phase got %b exp 1", MemWrite); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || mem_adr !== 32'h0) begin
            errors++; $display("FAIL rmw_abort got we %b adr %h exp 0/0", MemWrite, mem_adr);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready_after got %b exp 1", req_ready); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (resp_valid || MemWrite) seen++; end
        checks++;
        if (seen != 0 || mem[32'h3F0 >> 2] !== 32'h0102_0304) begin
            errors++; $display("FAIL rmw_no_effect got resp %0d mem %h exp 0/01020304", seen, mem[32'h3F0 >> 2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] adrs [3];
        logic [1:0]  szs  [3];
        logic        unss [3];
        int          acc_cyc[$];
        logic [31:0] got[$];
        logic        acc;
        int          cyc, k;
        poke(32'h3F4, $urandom);
        poke(32'h3F8, $urandom);
        poke(32'h3FC, $urandom);
        adrs[0] = 32'h3F4; szs[0] = 2'd2; unss[0] = 1'b0;
        adrs[1] = 32'h3F9; szs[1] = 2'd0; unss[1] = 1'b0;
        adrs[2] = 32'h3FE; szs[2] = 2'd1; unss[2] = 1'b1;
        cyc = 0; k = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_wdata = 32'h0;
        req_adr = adrs[0]; req_size = szs[0]; req_unsigned = unss[0];
        while (cyc < 40 && got.size() < 3) begin
            if (resp_valid) got.push_back(resp_rdata);
            acc = req_valid && req_ready;
            @(posedge clk);
            if (acc) begin acc_cyc.push_back(cyc); k++; end
            @(negedge clk);
            cyc++;
            if (k < 3) begin req_adr = adrs[k]; req_size = szs[k]; req_unsigned = unss[k]; end
            else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++;
        if (acc_cyc.size() != 3 || got.size() != 3) begin
            errors++; $display("FAIL b2b_count got acc %0d resp %0d exp 3/3", acc_cyc.size(), got.size());
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
                errors++; $display("FAIL b2b_spacing got %0d,%0d exp 3,3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== model_load(ref_mem[adrs[i][9:2]], adrs[i], szs[i], unss[i])) begin
                    errors++; $display("FAIL b2b_data%0d got %h exp %h", i, got[i],
                                       model_load(ref_mem[adrs[i][9:2]], adrs[i], szs[i], unss[i]));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wa, wdt, a, wd, exp_rd, exp_wd;
        logic er, t, ok, w, uns, trap;
        logic [1:0] sz, esz;
        int lat, nwr, exp_lat, exp_nwr;
        for (int i = 0; i < 8; i++) poke(32'h3E0 + 32'(4*i), $urandom);
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
            a = 32'h3E0 + 32'($urandom_range(0, 31)); wd = $urandom;
            trap = model_trap(sz, a);
            esz = (sz == 2'd3) ? 2'd2 : sz;
            exp_rd = 32'h0; exp_wd = 32'h0; exp_nwr = 0;
            if (trap) exp_lat = 1;
            else if (!w) begin exp_lat = 2; exp_rd = model_load(ref_mem[a[9:2]], a, esz, uns); end
            else begin
                exp_lat = (esz == 2'd2) ? 2 : 3; exp_nwr = 1;
                exp_wd = model_store(ref_mem[a[9:2]], a, esz, wd);
            end
            do_req(w, sz, uns, a, wd, rd, er, lat, nwr, wa, wdt, t, ok);
            if (w && !trap) ref_mem[a[9:2]] = exp_wd;
            checks++;
            if (!ok || lat != exp_lat || nwr != exp_nwr || er !== trap) begin
                errors++; $display("FAIL rnd%0d_ctrl got lat %0d wr %0d err %b exp %0d/%0d/%b", n, lat, nwr, er, exp_lat, exp_nwr, trap);
            end
            checks++;
            if (rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, rd, exp_rd); end
            if (exp_nwr == 1) begin
                checks++;
                if (wdt !== exp_wd || wa !== {a[31:2], 2'b00}) begin
                    errors++; $display("FAIL rnd%0d_wdata got %h@%h exp %h@%h", n, wdt, wa, exp_wd, {a[31:2], 2'b00});
                end
            end
        end
        @(negedge clk);
        for (int i = 248; i < 256; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rnd_mem%0d got %h exp %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_byte_loads();
        test_half_store();
        test_misaligned();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter N, default 32, meaning data and address width; only N=32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: core access request.
REQ-005 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-006 SHALL have port req_write, input, 1 bit: 1 selects store, 0 selects load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned, input, 1 bit: zero-extend sub-word loads when 1.
REQ-009 SHALL have ports req_adr and req_wdata, inputs, 32 bits each: byte address and store data (right-justified).
REQ-010 SHALL have ports resp_valid (output, 1 bit), resp_rdata (output, 32 bits) and resp_err (output, 1 bit): completion, load result and fault.
REQ-011 SHALL have memory-side ports mem_adr (output, 32), to_be_written_data (output, 32), MemWrite (output, 1) and read_data (input, 32); the memory is word-aligned and big-endian (byte offset 0 = bits 31:24), reads combinationally and writes on the clk edge.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, WRITE and DONE.
REQ-013 SHALL drive req_ready=1 only in IDLE, and SHALL latch the request on a cycle where req_valid and req_ready are both 1, then move to ACCESS.
REQ-014 SHALL drive mem_adr={adr[31:2],2'b00} from the latched address in ACCESS and WRITE, and SHALL drive mem_adr=0 elsewhere.
REQ-015 Load: in ACCESS, SHALL capture read_data, extract the byte or halfword at the offset, sign- or zero-extend it, then go to DONE; latency from acceptance to resp_valid is 2 cycles.
REQ-016 Word store: in ACCESS, SHALL assert MemWrite with to_be_written_data=wdata, then go to DONE (latency 2).
REQ-017 Sub-word store: in ACCESS, SHALL capture read_data; in WRITE, SHALL assert MemWrite with the captured word and the target lane replaced by wdata[7:0] or wdata[15:0], then go to DONE (latency 3).
REQ-018 In DONE, SHALL pulse resp_valid for exactly 1 cycle and return to IDLE; there is no response backpressure.
REQ-019 SHALL hold resp_rdata valid only while resp_valid is asserted; for stores, resp_rdata SHALL be 0.
REQ-020 SHALL assert MemWrite only in ACCESS (word store) or WRITE (sub-word store), never on loads, and never for more than 1 cycle per request.
REQ-021 SHALL ignore req_valid while not in IDLE; a new request SHALL be accepted in the cycle after DONE at the earliest.

Reset
REQ-022 While rst_n=0, SHALL force state=IDLE and req_ready=0, and SHALL drive resp_valid, resp_err, resp_rdata, MemWrite, mem_adr and to_be_written_data to 0, immediately and asynchronously.
REQ-023 Reset asserted mid-operation SHALL abandon the request with no memory write and no response; req_ready=1 SHALL follow in the first cycle after rst_n rises.

Configuration
REQ-024 With LSU_MISALIGN_TRAP_EN defined, any of the following SHALL skip memory access, go from IDLE to DONE, and respond with resp_err=1 and resp_rdata=0 (latency 1): a halfword with adr[0]=1, a word with adr[1:0]!=0, or req_size=11.
REQ-025 Without LSU_MISALIGN_TRAP_EN, resp_err SHALL be tied to 0; the address SHALL be aligned down to the access size, and size 11 SHALL be treated as a word access.

Structure
REQ-026 SHALL place the size encodings (SIZE_B, SIZE_H, SIZE_W) and the FSM state enum in package lsu_pkg.
REQ-027 SHALL use one combinational sub-module, lsu_byte_lane, for lane extraction with extension and for store merge.

Verification
REQ-028 Reset then load word: memory at 0x3E8 = 0x11223344, load word at 0x3E8 -> resp_valid 2 cycles after acceptance, resp_rdata=0x11223344, MemWrite never asserted.
REQ-029 Signed and unsigned byte loads: word 0x80FF7F01, signed byte at offset 1 -> 0xFFFFFFFF; unsigned byte at offset 0 -> 0x00000080.
REQ-030 Halfword store: word at 0x3EC = 0xAABBCCDD, store halfword 0x1234 at 0x3EE -> single MemWrite pulse in WRITE with data 0xAABB1234; later load word -> 0xAABB1234.
REQ-031 Misaligned halfword load at 0x3E9: with LSU_MISALIGN_TRAP_EN -> resp_err=1 after 1 cycle and no memory access; without -> aligned-down halfword at 0x3E8 returned with resp_err=0.
REQ-032 rst_n pulled low during WRITE of a byte store -> MemWrite drops immediately, memory is unchanged, no resp_valid, req_ready=1 in the first cycle after release.
REQ-033 Back-to-back: req_valid held high for 3 loads -> exactly one acceptance per 3 cycles, with responses in request order.
